// File: rtl/match_stats_pkg.sv
`default_nettype none
// ============================================================================
// Module      : match_stats_pkg
// Description : Shared types and constants for the match statistics display.
//               The package holds the two-digit BCD type, the segment
//               patterns, the hex-to-segment table and the polarity helper.
//               All segment constants are active-high: 1 means the segment
//               is lit, and bit 0 is segment a.
// Revision    : 1.0 - initial release
// ============================================================================
package match_stats_pkg;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    localparam logic [6:0] SEG_BLANK  = 7'h00;
    localparam logic [6:0] SEG_DASH   = 7'h40;   // segment g only
    localparam int         NUM_STATES = 9;

    // The table is indexed by the digit value. Entry 15 is the leftmost
    // element of the concatenation.
    localparam logic [15:0][6:0] c_hex_seg = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Converts an active-high pattern to the board's drive polarity.
    function automatic logic [6:0] seg_polarity(input logic [6:0] seg,
                                                input logic       active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter2.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter2
// Description : Two-digit BCD counter (00..99). When the count is 99, an
//               increment either holds the count (sat_mode=1) or wraps it to
//               00 (sat_mode=0). The synchronous clear takes priority over
//               any increment.
// Ports       : clk      - clock
//               clr      - synchronous clear, active-high
//               inc      - increment enable
//               sat_mode - 1: saturate at 99, 0: wrap to 00
//               count    - current value (tens, ones)
//               at_max   - count is 99
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter2
    import match_stats_pkg::*;
(
    input  logic  clk,
    input  logic  clr,
    input  logic  inc,
    input  logic  sat_mode,
    output bcd2_t count,
    output logic  at_max
);

    bcd2_t r_count;

    assign count  = r_count;
    assign at_max = (r_count.tens == 4'd9) && (r_count.ones == 4'd9);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            if (at_max) begin
                if (!sat_mode) begin
                    r_count <= '0;
                end
            end else if (r_count.ones == 4'd9) begin
                r_count.ones <= 4'd0;
                r_count.tens <= r_count.tens + 4'd1;
            end else begin
                r_count.ones <= r_count.ones + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/match_stats_display.sv
`default_nettype none
// ============================================================================
// Module      : match_stats_display
// Description : Statistics stage behind the run-of-four sequence detector.
//               It counts detection events (saturating at 99, with a sticky
//               overflow flag) and clock steps (wrapping at 99). It also
//               tracks the longest run of equal input bits. All values are
//               shown on the DE2 seven-segment displays.
//               Optional feature macro: MATCH_STATS_RUN_TRACK_EN. When it is
//               defined, run tracking is built and HEX4 shows the longest run.
//               When it is undefined, HEX4 is blank and SW[1] is ignored.
// Ports       : KEY[0]   - step clock (KEY[1] unused)
//               SW[0]    - synchronous reset, active-high
//               SW[1]    - serial input bit w
//               z        - detector match flag
//               state_oh - detector one-hot state (bit 0 = A)
//               HEX1:0   - match count, HEX3:2 - step count
//               HEX4     - longest run, HEX5 - detector state index
//               LEDG[0]  - z, LEDG[1] - sticky match-count overflow
// Revision    : 1.0 - initial release
// ============================================================================
module match_stats_display
    import match_stats_pkg::*;
#(
    parameter int HEX_ACTIVE_LOW = 1,
    parameter int RUN_SAT        = 15
)(
    input  logic [1:0]            KEY,
    input  logic [1:0]            SW,
    input  logic                  z,
    input  logic [NUM_STATES-1:0] state_oh,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX2,
    output logic [6:0]            HEX3,
    output logic [6:0]            HEX4,
    output logic [6:0]            HEX5,
    output logic [1:0]            LEDG
);

    localparam logic c_active_low = (HEX_ACTIVE_LOW != 0);

    logic  clk;
    logic  w_rst;
    logic  w_evt;
    logic  w_match_at_max;
    logic  w_step_at_max;
    bcd2_t w_match_cnt;
    bcd2_t w_step_cnt;
    logic  r_z_prev;
    logic  r_ovf;

    assign clk   = KEY[0];
    assign w_rst = SW[0];

    // z_prev loads z even during reset. A z held high through reset
    // therefore produces no event afterwards.
    always_ff @(posedge clk) begin
        r_z_prev <= z;
    end

    assign w_evt = z & ~r_z_prev;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_ovf <= 1'b0;
        end else if (w_evt && w_match_at_max) begin
            r_ovf <= 1'b1;
        end
    end

    bcd_counter2 u_match_cnt (
        .clk      (clk),
        .clr      (w_rst),
        .inc      (w_evt),
        .sat_mode (1'b1),
        .count    (w_match_cnt),
        .at_max   (w_match_at_max)
    );

    bcd_counter2 u_step_cnt (
        .clk      (clk),
        .clr      (w_rst),
        .inc      (1'b1),
        .sat_mode (1'b0),
        .count    (w_step_cnt),
        .at_max   (w_step_at_max)
    );

`ifdef MATCH_STATS_RUN_TRACK_EN
    localparam logic [3:0] c_run_sat = 4'(RUN_SAT);

    logic       r_cur_bit;
    logic       r_have_bit;
    logic [3:0] r_run_len;
    logic [3:0] r_max_run;
    logic [3:0] w_next_run;

    // The run restarts on the first bit after reset or when the bit changes.
    always_comb begin
        w_next_run = 4'd1;
        if (r_have_bit && (SW[1] == r_cur_bit)) begin
            w_next_run = (r_run_len >= c_run_sat) ? c_run_sat
                                                  : r_run_len + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_cur_bit  <= 1'b0;
            r_have_bit <= 1'b0;
            r_run_len  <= 4'd0;
            r_max_run  <= 4'd0;
        end else begin
            r_cur_bit  <= SW[1];
            r_have_bit <= 1'b1;
            r_run_len  <= w_next_run;
            if (w_next_run > r_max_run) begin
                r_max_run <= w_next_run;
            end
        end
    end

    assign HEX4 = seg_polarity(c_hex_seg[r_max_run], c_active_low);

    logic w_unused;
    assign w_unused = ^{KEY[1], w_step_at_max};
`else
    assign HEX4 = seg_polarity(SEG_BLANK, c_active_low);

    logic w_unused;
    assign w_unused = ^{KEY[1], SW[1], w_step_at_max, 4'(RUN_SAT)};
`endif

    // Decode the one-hot state. The number of set bits is counted as well,
    // so that any vector that is not one-hot shows a dash.
    logic [3:0] w_oh_idx;
    logic [3:0] w_oh_cnt;

    always_comb begin
        w_oh_idx = 4'd0;
        w_oh_cnt = 4'd0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (state_oh[i]) begin
                w_oh_idx = 4'(i);
                w_oh_cnt = w_oh_cnt + 4'd1;
            end
        end
    end

    assign HEX0 = seg_polarity(c_hex_seg[w_match_cnt.ones], c_active_low);
    assign HEX1 = seg_polarity(c_hex_seg[w_match_cnt.tens], c_active_low);
    assign HEX2 = seg_polarity(c_hex_seg[w_step_cnt.ones],  c_active_low);
    assign HEX3 = seg_polarity(c_hex_seg[w_step_cnt.tens],  c_active_low);
    assign HEX5 = seg_polarity((w_oh_cnt == 4'd1) ? c_hex_seg[w_oh_idx]
                                                  : SEG_DASH, c_active_low);

    assign LEDG = {r_ovf, z};

endmodule
`default_nettype wire

// File: tb/tb_match_stats_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_match_stats_display
// Description : Directed self-checking bench for match_stats_display with
//               default parameters (active-low segments, RUN_SAT = 15).
//               Expected segment codes come from the bench's own active-low
//               table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_match_stats_display;

    logic       clk;
    logic [1:0] sw;
    logic       z;
    logic [8:0] state_oh;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [1:0] ledg;

    int n_checks = 0;
    int n_errors = 0;

    match_stats_display dut (
        .KEY      ({1'b0, clk}),
        .SW       (sw),
        .z        (z),
        .state_oh (state_oh),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .HEX4     (hex4),
        .HEX5     (hex5),
        .LEDG     (ledg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low DE2 patterns for the digits 0..F, dash and blank.
    localparam logic [6:0] c_dash  = 7'h3F;
    localparam logic [6:0] c_blank = 7'h7F;

    function automatic logic [6:0] seg_exp(input int d);
        case (d)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;
            3: return 7'h30;   4: return 7'h19;   5: return 7'h12;
            6: return 7'h02;   7: return 7'h78;   8: return 7'h00;
            9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
           12: return 7'h46;  13: return 7'h21;  14: return 7'h06;
           15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks a two-digit display pair against a decimal value.
    task automatic check_pair(input string tag, input logic [6:0] hi,
                              input logic [6:0] lo, input int val);
        check_val({tag, "_tens"}, {25'd0, hi}, {25'd0, seg_exp(val / 10)});
        check_val({tag, "_ones"}, {25'd0, lo}, {25'd0, seg_exp(val % 10)});
    endtask

    // Expected HEX4 for a given longest run; blank when run tracking is
    // not built.
    function automatic logic [6:0] hex4_exp(input int run);
`ifdef MATCH_STATS_RUN_TRACK_EN
        return seg_exp(run);
`else
        return (run >= 0) ? c_blank : c_blank;
`endif
    endfunction

    // Applies the inputs for one step edge and moves to 1 time unit after
    // that edge.
    task automatic step(input logic rst, input logic w, input logic zin);
        sw = {w, rst};
        z  = zin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        sw       = 2'b01;
        z        = 1'b0;
        state_oh = 9'b000000001;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 1'b0);
        check_pair("rst_match", hex1, hex0, 0);
        check_pair("rst_step",  hex3, hex2, 0);
        check_val("rst_hex4", {25'd0, hex4}, {25'd0, hex4_exp(0)});
        check_val("rst_ovf",  {31'd0, ledg[1]}, 32'd0);
        check_val("rst_hex5", {25'd0, hex5}, {25'd0, seg_exp(0)});

        // z = 0,1,1,0,1 gives two events in five steps
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_pair("evt_match", hex1, hex0, 2);
        check_pair("evt_step",  hex3, hex2, 5);
        check_val("ledg0_z", {31'd0, ledg[0]}, 32'd1);

        // 101 separated pulses: saturation, overflow and step wrap
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 101; i++) begin
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1);
            if (i == 99) begin
                check_pair("sat99_match", hex1, hex0, 99);
                check_val("sat99_ovf", {31'd0, ledg[1]}, 32'd0);
            end
            if (i == 100) begin
                check_val("ovf_set", {31'd0, ledg[1]}, 32'd1);
                check_pair("wrap_step", hex3, hex2, 0);
            end
        end
        check_pair("ovf_match", hex1, hex0, 99);
        check_val("ovf_sticky", {31'd0, ledg[1]}, 32'd1);
        check_pair("ovf_step",  hex3, hex2, 2);

        // Run tracking: runs of 3, 2 and 5 give a longest run of 5
        step(1'b1, 1'b0, 1'b0);
        check_val("rst_ovf_clr", {31'd0, ledg[1]}, 32'd0);
        begin
            logic [9:0] bits;
            bits = 10'b1110011111;
            for (int i = 9; i >= 0; i--) step(1'b0, bits[i], 1'b0);
        end
        check_val("run5", {25'd0, hex4}, {25'd0, hex4_exp(5)});
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 9)  check_val("run14", {25'd0, hex4}, {25'd0, hex4_exp(14)});
            if (i == 10) check_val("run15", {25'd0, hex4}, {25'd0, hex4_exp(15)});
        end
        check_val("run_sat", {25'd0, hex4}, {25'd0, hex4_exp(15)});
        check_pair("run_match", hex1, hex0, 0);
        check_pair("run_step",  hex3, hex2, 22);

        // State decode is combinational
        state_oh = 9'b000100000; #1;
        check_val("hex5_f", {25'd0, hex5}, {25'd0, seg_exp(5)});
        state_oh = 9'b100000000; #1;
        check_val("hex5_i", {25'd0, hex5}, {25'd0, seg_exp(8)});
        state_oh = 9'b000000011; #1;
        check_val("hex5_two", {25'd0, hex5}, {25'd0, c_dash});
        state_oh = 9'b000000000; #1;
        check_val("hex5_zero", {25'd0, hex5}, {25'd0, c_dash});

        // z held high through reset is not counted afterwards
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_pair("hold_match", hex1, hex0, 0);
        check_pair("hold_step",  hex3, hex2, 3);

        // Reset wins over a rising z in the same edge
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_pair("rst_prio_match", hex1, hex0, 0);
        check_pair("rst_prio_step",  hex3, hex2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
